muldiv_ctrl: RTL



---
 rtl/muldiv_ctrl_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl shared types: FSM states, op select, width.
// Imported by muldiv_step and muldiv_ctrl.
package muldiv_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  function automatic logic [XLEN-1:0] abs_val(
    input logic [XLEN-1:0] v,
    input logic            sgn
  );
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration.
// Pure combinational; the 33-bit add/sub here is the critical path.
module muldiv_step
  import muldiv_ctrl_pkg::*;
(
  input  op_e             op_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  // mul: conditional add then shift right; div: shift left, trial subtract
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shl  = {hi_i, lo_i[XLEN-1]};
    diff = shl - {1'b0, opnd_i};
    hi_o = sum[XLEN:1];
    lo_o = {sum[0], lo_i[XLEN-1:1]};
    if (op_i == OP_DIV) begin
      hi_o = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ~diff[XLEN]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer for EXE.
// Optional MULDIV_EARLY_OUT_EN: multiply skips trailing zero iterations.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op_mul,
  input  logic            op_div,
  input  logic            sign,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo,
  output logic            div_by_zero
);

  state_e          state_q, state_d;
  op_e             op_q;
  logic            sign_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] m_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] res_hi_q, res_lo_q;
  logic            dbz_q;

  logic            accept;
  logic            take_new;
  logic            early_hit;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN-1:0] calc_hi, calc_lo;

  logic              mixed;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign accept   = start & (op_mul | op_div) & ~cancel;
  assign take_new = accept &
                    ((state_q == S_IDLE) || (state_q == S_DONE));

  muldiv_step u_step (
    .op_i   (op_q),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (m_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0]   rest_mask;
  logic [4:0]        rest_sh;
  logic [2*XLEN-1:0] shifted;

  // finish multiply in one barrel shift once no multiplier bits remain
  always_comb begin
    rest_mask = {XLEN{1'b1}} >> ({1'b0, cnt_q} + 6'd1);
    rest_sh   = 5'd31 - cnt_q;
    shifted   = {step_hi, step_lo} >> rest_sh;
    early_hit = (op_q == OP_MUL) &&
                ((step_lo & rest_mask) == '0);
    calc_hi   = step_hi;
    calc_lo   = step_lo;
    if (early_hit) begin
      calc_hi = shifted[2*XLEN-1:XLEN];
      calc_lo = shifted[XLEN-1:0];
    end
  end
`else
  assign early_hit = 1'b0;
  assign calc_hi   = step_hi;
  assign calc_lo   = step_lo;
`endif

  // sign correction applied in FIX
  always_comb begin
    mixed    = sign_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    prod_fix = {hi_q, lo_q};
    if (mixed) prod_fix = -{hi_q, lo_q};
    quo_fix  = mixed ? -lo_q : lo_q;
    rem_fix  = (sign_q & a_q[XLEN-1]) ? -hi_q : hi_q;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state and handshake outputs; cancel overrides everything
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE) & ~cancel;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_PREP;
      S_PREP: state_d = S_CALC;
      S_CALC: begin
        if (cnt_q == 5'd31 || early_hit) state_d = S_FIX;
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = accept ? S_PREP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel) state_d = S_IDLE;
  end

  // operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MUL;
      sign_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      if (take_new) begin
        op_q   <= op_mul ? OP_MUL : OP_DIV;
        sign_q <= sign;
        a_q    <= src1;
        b_q    <= src2;
      end
      unique case (state_q)
        S_PREP: begin
          cnt_q <= '0;
          hi_q  <= '0;
          if (op_q == OP_MUL) begin
            lo_q <= abs_val(b_q, sign_q);
            m_q  <= abs_val(a_q, sign_q);
          end else begin
            lo_q <= abs_val(a_q, sign_q);
            m_q  <= abs_val(b_q, sign_q);
          end
        end
        S_CALC: begin
          hi_q  <= calc_hi;
          lo_q  <= calc_lo;
          cnt_q <= cnt_q + 5'd1;
        end
        S_FIX: begin
          if (!cancel) begin
            if (op_q == OP_MUL) begin
              res_hi_q <= prod_fix[2*XLEN-1:XLEN];
              res_lo_q <= prod_fix[XLEN-1:0];
              dbz_q    <= 1'b0;
            end else if (b_q == '0) begin
              res_hi_q <= a_q;
              res_lo_q <= {XLEN{1'b1}};
              dbz_q    <= 1'b1;
            end else begin
              res_hi_q <= rem_fix;
              res_lo_q <= quo_fix;
              dbz_q    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign div_by_zero = dbz_q;

endmodule
